// File: rtl/mcycle.sv
// mcycle: iterative shift-add multiplier / restoring divider.
// One iteration per cycle; results commit on the last edge.
module mcycle #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    COMPUTING
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    count;
  logic [1:0]       op;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] m2;
  logic [WIDTH-1:0] op1_raw;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             is_signed_in;
  logic [WIDTH-1:0] mag1_in;
  logic [WIDTH-1:0] mag2_in;
  logic             last;
  logic             accept;

  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   dt;
  logic [WIDTH:0]   ddiff;
  logic             dge;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] nhi;
  logic [WIDTH-1:0] nlo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin1;
  logic [WIDTH-1:0]   fin2;

  assign Busy   = (state == COMPUTING);
  assign accept = (state == IDLE) && Start;
  assign last   = (count == CW'(WIDTH - 1));

  // operand magnitudes for signed ops (most-negative maps to itself)
  always_comb begin
    is_signed_in = ~MCycleOp[0];
    mag1_in = Operand1;
    mag2_in = Operand2;
    if (is_signed_in && Operand1[WIDTH-1])
      mag1_in = -Operand1;
    if (is_signed_in && Operand2[WIDTH-1])
      mag2_in = -Operand2;
  end

  // one multiply step and one restoring-divide step
  always_comb begin
    msum   = {1'b0, hi} + (lo[0] ? {1'b0, m1} : '0);
    mul_hi = msum[WIDTH:1];
    mul_lo = {msum[0], lo[WIDTH-1:1]};
    dt     = {hi, lo[WIDTH-1]};
    ddiff  = dt - {1'b0, m2};
    dge    = (dt >= {1'b0, m2});
    div_hi = dge ? ddiff[WIDTH-1:0] : dt[WIDTH-1:0];
    div_lo = {lo[WIDTH-2:0], dge};
    nhi    = op[1] ? div_hi : mul_hi;
    nlo    = op[1] ? div_lo : mul_lo;
  end

  // sign correction and divide-by-zero override
  always_comb begin
    prod     = {nhi, nlo};
    prod_neg = -prod;
    fin1     = nlo;
    fin2     = nhi;
    if (!op[1]) begin
      if (!op[0] && (s1 ^ s2)) begin
        fin1 = prod_neg[WIDTH-1:0];
        fin2 = prod_neg[2*WIDTH-1:WIDTH];
      end
    end else if (m2 == '0) begin
      fin1 = '1;
      fin2 = op1_raw;
    end else if (!op[0]) begin
      if (s1 ^ s2)
        fin1 = -nlo;
      if (s1)
        fin2 = -nhi;
    end
  end

  // state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (Start) state_nx = COMPUTING;
      COMPUTING: if (last) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // operand capture, iteration and result commit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count   <= '0;
      op      <= '0;
      m1      <= '0;
      m2      <= '0;
      op1_raw <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else if (accept) begin
      count   <= '0;
      op      <= MCycleOp;
      m1      <= mag1_in;
      m2      <= mag2_in;
      op1_raw <= Operand1;
      s1      <= Operand1[WIDTH-1];
      s2      <= Operand2[WIDTH-1];
      hi      <= '0;
      lo      <= MCycleOp[1] ? mag1_in : mag2_in;
    end else if (state == COMPUTING) begin
      count <= count + 1'b1;
      hi    <= nhi;
      lo    <= nlo;
      if (last) begin
        Result1 <= fin1;
        Result2 <= fin2;
      end
    end
  end

endmodule

// File: tb/tb_mcycle.sv
// tb_mcycle: directed vector table plus back-to-back
// and mid-operation reset sequences for mcycle.
module tb_mcycle;

  logic       CLK;
  logic       RESET;
  logic       Start;
  logic [1:0] MCycleOp;
  logic [3:0] Operand1;
  logic [3:0] Operand2;
  logic [3:0] Result1;
  logic [3:0] Result2;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  mcycle #(.WIDTH(4)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Start(Start),
    .MCycleOp(MCycleOp),
    .Operand1(Operand1),
    .Operand2(Operand2),
    .Result1(Result1),
    .Result2(Result2),
    .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r1;
    logic [3:0] r2;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // start one op; scramble operands while busy; count busy cycles
  task automatic run_op(input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, output int bc);
    @(negedge CLK);
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    MCycleOp = ~op;
    Operand1 = ~a;
    Operand2 = a ^ b ^ 4'h5;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!Busy) break;
      bc++;
    end
  endtask

  initial begin
    int bc;
    int lowc;
    vt[0]  = '{2'b01, 4'hf, 4'hf, 4'h1, 4'he};
    vt[1]  = '{2'b00, 4'hf, 4'hf, 4'h1, 4'h0};
    vt[2]  = '{2'b00, 4'h8, 4'h7, 4'h8, 4'hc};
    vt[3]  = '{2'b00, 4'h7, 4'ha, 4'h6, 4'hd};
    vt[4]  = '{2'b00, 4'h0, 4'hf, 4'h0, 4'h0};
    vt[5]  = '{2'b10, 4'hc, 4'h3, 4'hf, 4'hf};
    vt[6]  = '{2'b10, 4'ha, 4'hc, 4'h1, 4'he};
    vt[7]  = '{2'b10, 4'h3, 4'he, 4'hf, 4'h1};
    vt[8]  = '{2'b10, 4'hc, 4'hc, 4'h1, 4'h0};
    vt[9]  = '{2'b10, 4'h8, 4'hf, 4'h8, 4'h0};
    vt[10] = '{2'b11, 4'h8, 4'h4, 4'h2, 4'h0};
    vt[11] = '{2'b11, 4'h4, 4'h8, 4'h0, 4'h4};
    vt[12] = '{2'b11, 4'h0, 4'h5, 4'h0, 4'h0};
    vt[13] = '{2'b11, 4'h7, 4'h0, 4'hf, 4'h7};
    vt[14] = '{2'b10, 4'ha, 4'h0, 4'hf, 4'ha};
    vt[15] = '{2'b01, 4'h3, 4'h5, 4'hf, 4'h0};
    vt[16] = '{2'b11, 4'hd, 4'h3, 4'h4, 4'h1};
    vt[17] = '{2'b10, 4'h7, 4'h2, 4'h3, 4'h1};

    RESET = 1'b0;
    Start = 1'b0;
    MCycleOp = 2'b00;
    Operand1 = 4'h0;
    Operand2 = 4'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy", {7'd0, Busy}, 8'd0);
    chk("reset_r1", {4'd0, Result1}, 8'd0);
    chk("reset_r2", {4'd0, Result2}, 8'd0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, bc);
      chk($sformatf("v%0d_busy", i), 8'(bc), 8'd4);
      chk($sformatf("v%0d_res", i), {Result2, Result1},
          {vt[i].r2, vt[i].r1});
    end

    // back-to-back: Start held high; A = 5*3 unsigned, B = 9/2 unsigned
    @(negedge CLK);
    MCycleOp = 2'b01;
    Operand1 = 4'h5;
    Operand2 = 4'h3;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    MCycleOp = 2'b11;
    Operand1 = 4'h9;
    Operand2 = 4'h2;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!Busy) break;
      bc++;
    end
    chk("b2b_a_busy", 8'(bc), 8'd4);
    chk("b2b_a_res", {Result2, Result1}, 8'h0f);
    lowc = 0;
    for (int i = 0; i < 5; i++) begin
      if (Busy) break;
      lowc++;
      chk("b2b_hold", {Result2, Result1}, 8'h0f);
      @(negedge CLK);
    end
    chk("b2b_gap", 8'(lowc), 8'd1);
    Operand1 = 4'h1;
    Operand2 = 4'h1;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Busy) break;
      bc++;
      @(negedge CLK);
    end
    Start = 1'b0;
    chk("b2b_b_busy", 8'(bc), 8'd4);
    chk("b2b_b_res", {Result2, Result1}, 8'h14);

    // reset mid-multiply: async clear without a clock edge
    @(negedge CLK);
    MCycleOp = 2'b01;
    Operand1 = 4'hf;
    Operand2 = 4'hf;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("rst_mid_busy", {7'd0, Busy}, 8'd0);
    chk("rst_mid_res", {Result2, Result1}, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;
    run_op(2'b01, 4'hf, 4'hf, bc);
    chk("post_rst_busy", 8'(bc), 8'd4);
    chk("post_rst_res", {Result2, Result1}, 8'he1);

    // idle with Start low: outputs hold
    repeat (3) @(negedge CLK);
    chk("idle_busy", {7'd0, Busy}, 8'd0);
    chk("idle_hold", {Result2, Result1}, 8'he1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
